// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences instruction-fetch and data accesses onto one
// synchronous single-port RAM.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   if_req/if_addr           fetch request (word, read-only), held until if_ack
//   if_ack/if_err/if_rdata   fetch completion pulse, misalignment flag, word
//   d_req/d_we/d_size/d_addr/d_wdata  data request (load/store, byte/half/word)
//   d_ack/d_err/d_rdata      data completion pulse, error flag, zero-extended load
//   ram_cs/we/oe/size/addr/wdata, ram_rdata  registered RAM interface
//   busy                     high whenever the FSM is not idle
//
// Optional build macro ROUND_ROBIN_EN: alternate the tie-break winner when
// both requesters are present; otherwise data always wins ties.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic                  if_err,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [1:0]            d_size,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic                  d_err,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [1:0]            ram_size,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

  state_e                  state_q, state_d;
  logic                    grant_data_q;  // owner of the transaction in flight
  logic                    pick_data;     // arbitration result while idle
  logic                    resp_data;     // which port the RESP entry addresses
  logic                    req_we;
  logic                    req_err;
  logic [1:0]              req_size;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   load_data;

`ifdef ROUND_ROBIN_EN
  // Tie-break pointer: names the requester that wins when both are present.
  // Starts on data and flips to the other port after every grant.
  logic prio_data_q;
  assign pick_data = d_req & (~if_req | prio_data_q);
`else
  assign pick_data = d_req;
`endif

  assign busy      = (state_q != StIdle);
  assign resp_data = (state_q == StIdle) ? pick_data : grant_data_q;

  // Selected request payload and its legality (fetch is always a word).
  always_comb begin
    req_size = 2'b11;
    req_addr = if_addr;
    req_we   = 1'b0;
    req_err  = 1'b0;
    if (pick_data) begin
      req_size = d_size;
      req_addr = d_addr;
      req_we   = d_we;
    end
    case (req_size)
      2'b01:   req_err = 1'b1;
      2'b10:   req_err = req_addr[0];
      2'b11:   req_err = |req_addr[1:0];
      default: req_err = 1'b0;
    endcase
  end

  // RAM returns LSB-aligned data; clear the bytes beyond the access size.
  always_comb begin
    load_data = '0;
    case (ram_size)
      2'b00:   load_data[7:0]  = ram_rdata[7:0];
      2'b10:   load_data[15:0] = ram_rdata[15:0];
      default: load_data       = ram_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (d_req || if_req) state_d = req_err ? StResp : StIssue;
      StIssue:   state_d = ram_we ? StResp : StCapture;
      StCapture: state_d = StResp;
      StResp:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_data_q <= 1'b1;
`ifdef ROUND_ROBIN_EN
      prio_data_q  <= 1'b1;
`endif
      ram_cs       <= 1'b0;
      ram_we       <= 1'b0;
      ram_oe       <= 1'b0;
      ram_size     <= '0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      if_ack       <= 1'b0;
      if_err       <= 1'b0;
      if_rdata     <= '0;
      d_ack        <= 1'b0;
      d_err        <= 1'b0;
      d_rdata      <= '0;
    end else begin
      state_q <= state_d;

      // Controls are derived from the next state so they are registered yet
      // line up exactly with ISSUE/CAPTURE.
      ram_cs <= (state_d == StIssue) || (state_d == StCapture);
      ram_we <= (state_d == StIssue) && req_we;
      ram_oe <= ((state_d == StIssue) && !req_we) || (state_d == StCapture);

      if (state_q == StIdle && state_d != StIdle) begin
        grant_data_q <= pick_data;
`ifdef ROUND_ROBIN_EN
        prio_data_q  <= ~pick_data;
`endif
        ram_size     <= req_size;
        ram_addr     <= req_addr;
        ram_wdata    <= pick_data ? d_wdata : '0;
      end

      // Ack/err are one-cycle pulses on the granted port only.
      if_ack <= (state_d == StResp) && !resp_data;
      d_ack  <= (state_d == StResp) && resp_data;
      if_err <= (state_d == StResp) && !resp_data && (state_q == StIdle);
      d_err  <= (state_d == StResp) && resp_data && (state_q == StIdle);

      // Read data only changes on entry to RESP for loads/fetches and errors;
      // stores leave the previous value in place.
      if (state_d == StResp && state_q != StIssue) begin
        if (resp_data) begin
          d_rdata  <= (state_q == StCapture) ? load_data : '0;
        end else begin
          if_rdata <= (state_q == StCapture) ? load_data : '0;
        end
      end
    end
  end

endmodule
